// File: rtl/aud_i2s_tx_if.sv
// Sample-pair handshake between the DSP sample path and the I2S transmitter.
interface aud_i2s_tx_if #(
    parameter int unsigned DATA_W = 16
);
    logic              i_valid;
    logic [DATA_W-1:0] i_left;
    logic [DATA_W-1:0] i_right;
    logic              o_ready;

    modport master (
        output i_valid,
        output i_left,
        output i_right,
        input  o_ready
    );

    modport slave (
        input  i_valid,
        input  i_left,
        input  i_right,
        output o_ready
    );
endinterface

// File: rtl/aud_i2s_tx.sv
// Stereo serial-audio transmitter: one-frame holding buffer, LR-clock edge
// detection and MSB-first serialisation in I2S or left-justified format.
module aud_i2s_tx #(
    parameter int unsigned DATA_W   = 16,
    parameter bit          I2S_MODE = 1'b1,
    parameter bit          MONO     = 1'b0
) (
    input  logic        i_bclk,
    input  logic        i_rst,
    input  logic        i_daclrck,
    input  logic        i_en,
    input  logic        i_mute,
    aud_i2s_tx_if.slave smp,
    output logic        o_aud_dacdat,
    output logic        o_underflow,
    output logic        o_chan,
    output logic [1:0]  o_state
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SHIFT = 2'd2,
        ST_PAD   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dat_q, dat_d;
    logic              chan_q, chan_d;

    logic              lrclk_q, lrclk_d;
    logic              full_q, full_d;
    logic [DATA_W-1:0] buf_left_q, buf_left_d;
    logic [DATA_W-1:0] buf_right_q, buf_right_d;
    logic [DATA_W-1:0] act_left_q, act_left_d;
    logic [DATA_W-1:0] act_right_q, act_right_d;
    logic              underflow_q, underflow_d;

    logic              lr_edge;
    logic              frame_start;
    logic              left_load;
    logic              accept;
    logic [DATA_W-1:0] sel_sample;

    // Edge detect, holding-buffer handshake, frame load and sample selection.
    always_comb begin
        lrclk_d     = i_daclrck;
        lr_edge     = (i_daclrck != lrclk_q);
        frame_start = lr_edge & i_en;
        left_load   = frame_start & ~i_daclrck;
        accept      = smp.i_valid & ~full_q;

        full_d      = full_q;
        buf_left_d  = buf_left_q;
        buf_right_d = buf_right_q;
        act_left_d  = act_left_q;
        act_right_d = act_right_q;
        underflow_d = 1'b0;

        if (left_load) begin
            full_d = 1'b0;
            if (full_q) begin
                act_left_d  = buf_left_q;
                act_right_d = buf_right_q;
            end else begin
                act_left_d  = '0;
                act_right_d = '0;
                underflow_d = 1'b1;
            end
        end

        // Accept only happens while empty, so a same-cycle load has already
        // taken the old contents (zero pair) before the new pair lands here.
        if (accept) begin
            buf_left_d  = smp.i_left;
            buf_right_d = smp.i_right;
            full_d      = 1'b1;
        end

        // The left slot must use the pair being loaded this very cycle.
        sel_sample = '0;
        if (i_mute) begin
            sel_sample = '0;
        end else if (!i_daclrck) begin
            sel_sample = full_q ? buf_left_q : '0;
        end else begin
            sel_sample = MONO ? act_left_q : act_right_q;
        end
    end

    // Holding buffer, active pair, LR clock history and underflow pulse.
    always_ff @(posedge i_bclk or posedge i_rst) begin
        if (i_rst) begin
            lrclk_q     <= 1'b0;
            full_q      <= 1'b0;
            buf_left_q  <= '0;
            buf_right_q <= '0;
            act_left_q  <= '0;
            act_right_q <= '0;
            underflow_q <= 1'b0;
        end else begin
            lrclk_q     <= lrclk_d;
            full_q      <= full_d;
            buf_left_q  <= buf_left_d;
            buf_right_q <= buf_right_d;
            act_left_q  <= act_left_d;
            act_right_q <= act_right_d;
            underflow_q <= underflow_d;
        end
    end

    // Serialiser next state: any edge restarts the word, otherwise step the FSM.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        dat_d   = 1'b0;
        chan_d  = chan_q;

        if (lr_edge) begin
            if (i_en) begin
                chan_d = i_daclrck;
                if (I2S_MODE) begin
                    state_d = ST_DELAY;
                    shift_d = sel_sample;
                    cnt_d   = '0;
                end else begin
                    // Left-justified: the MSB goes out on the edge-detect cycle.
                    state_d = ST_SHIFT;
                    dat_d   = sel_sample[DATA_W-1];
                    shift_d = {sel_sample[DATA_W-2:0], 1'b0};
                    cnt_d   = CNT_W'(1);
                end
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_DELAY: begin
                    state_d = ST_SHIFT;
                    dat_d   = shift_q[DATA_W-1];
                    shift_d = {shift_q[DATA_W-2:0], 1'b0};
                    cnt_d   = CNT_W'(1);
                end
                ST_SHIFT: begin
                    if (cnt_q == CNT_W'(DATA_W)) begin
                        state_d = ST_PAD;
                    end else begin
                        dat_d   = shift_q[DATA_W-1];
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                ST_PAD: begin
                    state_d = ST_PAD;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Serialiser registers; all outputs come straight from these flops.
    always_ff @(posedge i_bclk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            dat_q   <= 1'b0;
            chan_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
            chan_q  <= chan_d;
        end
    end

    assign smp.o_ready  = ~full_q;
    assign o_aud_dacdat = dat_q;
    assign o_underflow  = underflow_q;
    assign o_chan       = chan_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_aud_i2s_tx.sv
// Randomized bench for aud_i2s_tx: three configurations share one clock and
// stimulus and are compared every cycle against a slot-position model.
module tb_aud_i2s_tx;

    localparam int NDUT = 3;
    localparam int W    [NDUT] = '{16, 16, 24};
    localparam int DLY  [NDUT] = '{1, 0, 1};
    localparam int MNO  [NDUT] = '{0, 0, 1};

    logic        clk = 1'b0;
    logic        rst;
    logic        lr;
    logic        en;
    logic        mute;
    logic        valid;
    logic [31:0] l_in;
    logic [31:0] r_in;

    logic [2:0]  dat;
    logic [2:0]  uf;
    logic [2:0]  ch;
    logic [5:0]  st;
    logic [2:0]  rdy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    aud_i2s_tx_if #(.DATA_W(16)) if0 ();
    aud_i2s_tx_if #(.DATA_W(16)) if1 ();
    aud_i2s_tx_if #(.DATA_W(24)) if2 ();

    assign if0.i_valid = valid;
    assign if0.i_left  = l_in[15:0];
    assign if0.i_right = r_in[15:0];
    assign if1.i_valid = valid;
    assign if1.i_left  = l_in[15:0];
    assign if1.i_right = r_in[15:0];
    assign if2.i_valid = valid;
    assign if2.i_left  = l_in[23:0];
    assign if2.i_right = r_in[23:0];
    assign rdy = {if2.o_ready, if1.o_ready, if0.o_ready};

    aud_i2s_tx #(.DATA_W(16), .I2S_MODE(1'b1), .MONO(1'b0)) u_i2s (
        .i_bclk(clk), .i_rst(rst), .i_daclrck(lr), .i_en(en), .i_mute(mute),
        .smp(if0.slave), .o_aud_dacdat(dat[0]), .o_underflow(uf[0]),
        .o_chan(ch[0]), .o_state(st[1:0])
    );

    aud_i2s_tx #(.DATA_W(16), .I2S_MODE(1'b0), .MONO(1'b0)) u_lj (
        .i_bclk(clk), .i_rst(rst), .i_daclrck(lr), .i_en(en), .i_mute(mute),
        .smp(if1.slave), .o_aud_dacdat(dat[1]), .o_underflow(uf[1]),
        .o_chan(ch[1]), .o_state(st[3:2])
    );

    aud_i2s_tx #(.DATA_W(24), .I2S_MODE(1'b1), .MONO(1'b1)) u_mono24 (
        .i_bclk(clk), .i_rst(rst), .i_daclrck(lr), .i_en(en), .i_mute(mute),
        .smp(if2.slave), .o_aud_dacdat(dat[2]), .o_underflow(uf[2]),
        .o_chan(ch[2]), .o_state(st[5:4])
    );

    // Reference model state (shared: every configuration sees the same frames).
    bit          m_lr, m_full, m_run, m_ch, m_mute, m_uf, acc_last;
    logic [31:0] m_bl, m_br, m_al, m_ar;
    int          m_pos;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_lr = 0; m_full = 0; m_run = 0; m_ch = 0; m_mute = 0; m_uf = 0;
        m_bl = '0; m_br = '0; m_al = '0; m_ar = '0; m_pos = 0; acc_last = 0;
    endtask

    // Applies the inputs present at a rising edge to the model.
    task automatic model_step();
        bit edge_seen, acc;
        acc_last = 0;
        if (rst) begin
            model_reset();
            return;
        end
        m_uf      = 0;
        edge_seen = (lr != m_lr);
        m_lr      = lr;
        acc       = valid && !m_full;
        if (edge_seen) begin
            if (en) begin
                if (!lr) begin
                    if (m_full) begin
                        m_al = m_bl; m_ar = m_br; m_full = 0;
                    end else begin
                        m_al = '0; m_ar = '0; m_uf = 1;
                    end
                end
                m_run = 1; m_pos = 0; m_ch = lr; m_mute = mute;
            end else begin
                m_run = 0;
            end
        end else if (m_run) begin
            m_pos++;
        end
        if (acc) begin
            m_bl = l_in; m_br = r_in; m_full = 1;
        end
        acc_last = acc;
    endtask

    function automatic logic [31:0] word_of(int d);
        logic [31:0] s;
        logic [63:0] msk;
        msk = (64'd1 << W[d]) - 64'd1;
        if (m_mute)                  s = '0;
        else if (!m_ch || MNO[d] != 0) s = m_al;
        else                         s = m_ar;
        return s & msk[31:0];
    endfunction

    function automatic logic [31:0] exp_dat(int d);
        int k;
        logic [31:0] wd;
        if (!m_run) return 0;
        if (DLY[d] != 0 && m_pos == 0) return 0;
        k = m_pos - DLY[d];
        if (k >= W[d]) return 0;
        wd = word_of(d);
        return {31'd0, wd[W[d]-1-k]};
    endfunction

    function automatic logic [31:0] exp_state(int d);
        if (!m_run) return 0;
        if (DLY[d] != 0 && m_pos == 0) return 1;
        if (m_pos - DLY[d] < W[d]) return 2;
        return 3;
    endfunction

    task automatic check_all();
        for (int d = 0; d < NDUT; d++) begin
            check_eq($sformatf("dacdat%0d", d), {31'd0, dat[d]}, exp_dat(d));
            check_eq($sformatf("state%0d", d), {30'd0, st[2*d +: 2]}, exp_state(d));
            check_eq($sformatf("underflow%0d", d), {31'd0, uf[d]}, {31'd0, m_uf});
            check_eq($sformatf("chan%0d", d), {31'd0, ch[d]}, {31'd0, m_ch});
            check_eq($sformatf("ready%0d", d), {31'd0, rdy[d]}, {31'd0, !m_full});
        end
    endtask

    logic [31:0] dir_l [4] = '{32'h0000A5C3, 32'h00008001, 32'h00C0FFEE, 32'h00007FFF};
    logic [31:0] dir_r [4] = '{32'h00001234, 32'h00007FFF, 32'h00123456, 32'h00008000};
    int dir_idx  = 0;
    int slot_rem = 0;
    int rst_hold = 0;
    bit did_rst  = 0;

    // Chooses the inputs for the next rising edge according to the test phase.
    task automatic gen_inputs();
        int phase, pct;
        phase = (cyc < 600) ? 0 : (cyc < 1400) ? 1 : (cyc < 3400) ? 2 : 3;
        pct   = (phase == 0 || phase == 3) ? 100 : (phase == 1) ? 3 : 20;
        if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) rst = 0;
        end
        if (acc_last) valid = 0;
        if (slot_rem == 0) begin
            lr       = ~lr;
            slot_rem = (phase == 2) ? int'($urandom_range(10, 40)) : 32;
            mute     = (phase == 1 || phase == 2) ? ($urandom_range(0, 9) == 0) : 1'b0;
        end
        slot_rem--;
        en = (phase == 2) ? ($urandom_range(0, 19) != 0) : 1'b1;
        if (!valid) begin
            if (dir_idx < 4) begin
                l_in = dir_l[dir_idx]; r_in = dir_r[dir_idx];
                valid = 1; dir_idx++;
            end else if ($urandom_range(0, 99) < pct) begin
                l_in = $urandom; r_in = $urandom;
                valid = 1;
            end
        end
    endtask

    initial begin
        rst = 1; lr = 0; en = 0; mute = 0; valid = 0; l_in = '0; r_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst = 0;
        for (cyc = 0; cyc < 4000; cyc++) begin
            gen_inputs();
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
            // Asynchronous reset landing mid-word, at bit 5 of the I2S instance.
            if (cyc >= 3400 && !did_rst && rst == 0 && m_run && m_pos == 6) begin
                did_rst = 1;
                rst = 1;
                #1;
                for (int d = 0; d < NDUT; d++) begin
                    check_eq($sformatf("rst_dacdat%0d", d), {31'd0, dat[d]}, 32'd0);
                    check_eq($sformatf("rst_state%0d", d), {30'd0, st[2*d +: 2]}, 32'd0);
                    check_eq($sformatf("rst_ready%0d", d), {31'd0, rdy[d]}, 32'd1);
                end
                model_reset();
                rst_hold = 3;
            end
        end
        check_eq("rst_mid_word_seen", {31'd0, did_rst}, 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
